slink_link_bringup: RTL and testbench
=====================================

# slink_link_bringup

Hardware bring-up sequencer for one serial link instance. It replaces the software start-up routine. It sits directly upstream of the link's APB configuration port and acts as the APB master. On request it runs the fixed control sequence: release reset, assert reset, enable clock, wait, de-isolate AXI. It then polls the isolation status register until both isolation bits clear, and reports done or error.

## Interface
Parameters:
- `AddrWidth`, 32: APB address width.
- `DataWidth`, 32: APB data width; must be ≥ 10.
- `CtrlOffset`, 32'h0: byte address of the link CTRL register.
- `IsolatedOffset`, 32'h4: byte address of the link ISOLATED status register.
- `WaitCycles`, 50: idle cycles between clock enable and de-isolation; must be ≥ 1.
- `MaxPolls`, 1024: ISOLATED reads allowed before timeout; must be ≥ 1.

Ports:
- `clk_i`, in, 1: the block's only clock.
- `rst_i`, in, 1: reset, synchronous, active-high.
- `start_i`, in, 1: single-cycle request to run the sequence.
- `busy_o`, out, 1: sequence in progress.
- `done_o`, out, 1: sequence finished successfully; sticky.
- `error_o`, out, 1: sequence aborted; sticky.
- `err_code_o`, out, 2: error cause. 0 = none, 1 = pslverr, 2 = poll timeout.
- `paddr_o`, out, AddrWidth: APB address.
- `psel_o`, out, 1: APB select.
- `penable_o`, out, 1: APB enable.
- `pwrite_o`, out, 1: APB write.
- `pwdata_o`, out, DataWidth: APB write data.
- `pstrb_o`, out, DataWidth/8: APB strobes; always all-ones during writes.
- `pready_i`, in, 1: APB ready.
- `prdata_i`, in, DataWidth: APB read data.
- `pslverr_i`, in, 1: APB slave error.

## Operation
- FSM states: IDLE, W_RSTREL, W_RSTASS, W_CLKEN, WAIT, W_DEISO, R_ISO, DONE, ERROR.
- **IDLE → W_RSTREL:** on `start_i`.
- **Start in DONE or ERROR:** `start_i` also starts a new run. It clears `done_o`, `error_o`, `err_code_o` and the poll counter on the same edge.
- **Start while busy:** `start_i` is ignored.
- **Writes:** each W_* state issues one APB write to `CtrlOffset`, in this order:
  - W_RSTREL: 32'h300.
  - W_RSTASS: 32'h302.
  - W_CLKEN: 32'h303.
  - W_DEISO: 32'h003.
- **Write data width:** upper bits of `pwdata_o` above bit 9 are zero.
- **WAIT:** counts `WaitCycles` cycles with `psel_o` = 0, then moves to W_DEISO.
- **R_ISO:** issues an APB read of `IsolatedOffset`, then checks the captured data.
  - Bits [1:0] == 0 → DONE.
  - Bits [1:0] != 0 → increment the poll counter and reissue the read.
  - Read data bits above [1:0] are ignored.
- **Poll timeout:** when a nonzero read makes the poll count reach `MaxPolls` → ERROR with code 2.
- **Slave error:** `pslverr_i` = 1 at any completed access → ERROR with code 1. The remaining steps are skipped.
- **DONE / ERROR:** `psel_o` = 0. Outputs hold until `start_i` or `rst_i`.
- **Flag encoding:** `busy_o` = 1 in every state except IDLE, DONE and ERROR. `done_o` = (state == DONE). `error_o` = (state == ERROR).

## Timing
- **APB transfer phases:**
  - Setup phase: one cycle, with `psel_o` = 1 and `penable_o` = 0.
  - Access phase: `psel_o` = `penable_o` = 1 until `pready_i` = 1.
- **Transfer completion:** a transfer completes on the edge where `penable_o` && `pready_i`. The next state's setup phase starts on the following cycle. There is no idle cycle between back-to-back transfers.
- **Stable signals:** `paddr_o`, `pwrite_o`, `pwdata_o` and `pstrb_o` are stable from setup through access.
- **Read capture:** `prdata_i` is sampled only at read completion.
- **Zero-wait slave, already de-isolated, one poll:** `start_i` at cycle 0 → `done_o` high at cycle 1 + 8 + `WaitCycles` + 2 + 2 = `WaitCycles` + 13.
  - Each transfer takes 2 cycles (setup + access).
- **Reset values:** all outputs 0 while and after `rst_i`; state = IDLE; counters = 0.
- **Reset mid-transfer:** `psel_o` and `penable_o` drop on the reset edge. This is the only permitted abort of an APB transfer.
- **Extended `pready_i` low:** the sequencer waits indefinitely. There is no transfer timeout; only polls time out.
- **Counter widths:**
  - Wait counter: $clog2(`WaitCycles`+1) bits.
  - Poll counter: $clog2(`MaxPolls`+1) bits, saturating.

## Structure
- **Package `slink_bringup_pkg`:**
  - the state enum `bringup_state_e`;
  - CTRL encodings: `CtrlRstRel` = 'h300, `CtrlRstAss` = 'h302, `CtrlClkEn` = 'h303, `CtrlDeIso` = 'h003;
  - error codes `ErrNone`, `ErrSlv`, `ErrTimeout`.
- **Sub-module `slink_apb_single_txn`:** a single-transfer APB master.
  - Inputs: req/addr/write/wdata.
  - Outputs: ack, rdata, slverr, and the APB pins.
- **Top-level FSM:** sequences the sub-module and owns the wait and poll counters.

## Test plan
- **Nominal run:** zero-wait slave; ISOLATED reads 0 at the first poll → writes observed in order 0x300, 0x302, 0x303, 0x003 to `CtrlOffset`; one read of `IsolatedOffset`; `done_o` = 1 at cycle `WaitCycles` + 13; `busy_o` = 0.
- **Slow isolation release:** ISOLATED returns 0x3, 0x1, then 0x0 → exactly 3 reads; `done_o` = 1; `error_o` = 0.
- **Poll timeout:** `MaxPolls` = 4; ISOLATED stuck at 0x2 → exactly 4 reads; `error_o` = 1; `err_code_o` = 2; no further APB traffic.
- **Slave error:** `pslverr_i` = 1 on the 0x302 write → ERROR with code 1; writes 0x303 and 0x003 are never issued.
- **Slave wait states:** random `pready_i` delays of 0–5 cycles → address and data stable through each access; sequence order unchanged.
- **Reset and restart:**
  - `rst_i` during the WAIT state → all outputs 0 next cycle.
  - `start_i` afterwards → full sequence replays from 0x300.
  - `start_i` while busy → ignored.

Source files
------------

// File: rtl/slink_bringup_pkg.sv
// Shared types and CTRL register encodings for the serial-link bring-up sequencer.
package slink_bringup_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StWRstRel,
        StWRstAss,
        StWClkEn,
        StWait,
        StWDeIso,
        StRIso,
        StDone,
        StError
    } bringup_state_e;

    // Sub-steps of one ISOLATED poll: bus transfer, latch status bits, evaluate.
    typedef enum logic [1:0] {
        RdXfer,
        RdCapture,
        RdCheck
    } rd_step_e;

    typedef enum logic [1:0] {
        ErrNone    = 2'd0,
        ErrSlv     = 2'd1,
        ErrTimeout = 2'd2
    } err_code_e;

    localparam logic [9:0] CtrlRstRel = 10'h300;
    localparam logic [9:0] CtrlRstAss = 10'h302;
    localparam logic [9:0] CtrlClkEn  = 10'h303;
    localparam logic [9:0] CtrlDeIso  = 10'h003;

endpackage

// File: rtl/slink_apb_single_txn.sv
// Single-transfer APB master: setup while req_i is high, then access until pready_i.
module slink_apb_single_txn #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_i,
    input  logic [AddrWidth-1:0]   addr_i,
    input  logic                   write_i,
    input  logic [DataWidth-1:0]   wdata_i,
    output logic                   ack_o,
    output logic [DataWidth-1:0]   rdata_o,
    output logic                   slverr_o,
    output logic [AddrWidth-1:0]   paddr_o,
    output logic                   psel_o,
    output logic                   penable_o,
    output logic                   pwrite_o,
    output logic [DataWidth-1:0]   pwdata_o,
    output logic [DataWidth/8-1:0] pstrb_o,
    input  logic                   pready_i,
    input  logic [DataWidth-1:0]   prdata_i,
    input  logic                   pslverr_i
);

    logic                 access_q, access_d;
    logic [DataWidth-1:0] rdata_q, rdata_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            access_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            access_q <= access_d;
            rdata_q  <= rdata_d;
        end
    end

    // Setup is combinational on req_i so a new transfer can follow completion directly.
    always_comb begin
        access_d = access_q ? !pready_i : req_i;
        rdata_d  = (ack_o && !write_i) ? prdata_i : rdata_q;
    end

    always_comb begin
        ack_o     = access_q && pready_i;
        slverr_o  = ack_o && pslverr_i;
        rdata_o   = rdata_q;
        psel_o    = req_i || access_q;
        penable_o = access_q;
        paddr_o   = addr_i;
        pwrite_o  = write_i;
        pwdata_o  = write_i ? wdata_i : '0;
        pstrb_o   = write_i ? '1 : '0;
    end

endmodule

// File: rtl/slink_link_bringup.sv
// Bring-up sequencer: drives the link CTRL write sequence over APB and polls ISOLATED.
module slink_link_bringup
    import slink_bringup_pkg::*;
#(
    parameter int unsigned          AddrWidth      = 32,
    parameter int unsigned          DataWidth      = 32,
    parameter logic [AddrWidth-1:0] CtrlOffset     = AddrWidth'(32'h0),
    parameter logic [AddrWidth-1:0] IsolatedOffset = AddrWidth'(32'h4),
    parameter int unsigned          WaitCycles     = 50,
    parameter int unsigned          MaxPolls       = 1024
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   error_o,
    output logic [1:0]             err_code_o,
    output logic [AddrWidth-1:0]   paddr_o,
    output logic                   psel_o,
    output logic                   penable_o,
    output logic                   pwrite_o,
    output logic [DataWidth-1:0]   pwdata_o,
    output logic [DataWidth/8-1:0] pstrb_o,
    input  logic                   pready_i,
    input  logic [DataWidth-1:0]   prdata_i,
    input  logic                   pslverr_i
);

    localparam int unsigned      WaitW    = $clog2(WaitCycles + 1);
    localparam int unsigned      PollW    = $clog2(MaxPolls + 1);
    localparam logic [WaitW-1:0] WaitLast = WaitW'(WaitCycles - 1);
    localparam logic [PollW-1:0] PollLast = PollW'(MaxPolls - 1);
    localparam logic [PollW-1:0] PollMax  = PollW'(MaxPolls);

    bringup_state_e   state_q, state_d;
    rd_step_e         rd_step_q, rd_step_d;
    logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
    logic [PollW-1:0] poll_cnt_q, poll_cnt_d;
    logic [1:0]       iso_q, iso_d;
    err_code_e        err_q, err_d;

    logic                 txn_req, txn_write, txn_ack, txn_slverr;
    logic [AddrWidth-1:0] txn_addr;
    logic [DataWidth-1:0] txn_wdata, txn_rdata;
    logic                 unused_rdata_hi;

    assign unused_rdata_hi = ^txn_rdata[DataWidth-1:2];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            rd_step_q  <= RdXfer;
            wait_cnt_q <= '0;
            poll_cnt_q <= '0;
            iso_q      <= '0;
            err_q      <= ErrNone;
        end else begin
            state_q    <= state_d;
            rd_step_q  <= rd_step_d;
            wait_cnt_q <= wait_cnt_d;
            poll_cnt_q <= poll_cnt_d;
            iso_q      <= iso_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rd_step_d  = rd_step_q;
        wait_cnt_d = wait_cnt_q;
        poll_cnt_d = poll_cnt_q;
        iso_d      = iso_q;
        err_d      = err_q;
        unique case (state_q)
            StIdle, StDone, StError: begin
                if (start_i) begin
                    state_d    = StWRstRel;
                    rd_step_d  = RdXfer;
                    wait_cnt_d = '0;
                    poll_cnt_d = '0;
                    err_d      = ErrNone;
                end
            end
            StWRstRel: if (txn_ack) state_d = StWRstAss;
            StWRstAss: if (txn_ack) state_d = StWClkEn;
            StWClkEn: begin
                if (txn_ack) begin
                    state_d    = StWait;
                    wait_cnt_d = '0;
                end
            end
            StWait: begin
                if (wait_cnt_q == WaitLast) begin
                    state_d    = StWDeIso;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + WaitW'(1);
                end
            end
            StWDeIso: begin
                if (txn_ack) begin
                    state_d   = StRIso;
                    rd_step_d = RdXfer;
                end
            end
            StRIso: begin
                unique case (rd_step_q)
                    RdXfer:    if (txn_ack) rd_step_d = RdCapture;
                    RdCapture: begin
                        iso_d     = txn_rdata[1:0];
                        rd_step_d = RdCheck;
                    end
                    RdCheck: begin
                        if (iso_q == 2'b00) begin
                            state_d = StDone;
                        end else begin
                            if (poll_cnt_q != PollMax) poll_cnt_d = poll_cnt_q + PollW'(1);
                            if (poll_cnt_q >= PollLast) begin
                                state_d = StError;
                                err_d   = ErrTimeout;
                            end else begin
                                rd_step_d = RdXfer;
                            end
                        end
                    end
                    default: rd_step_d = RdXfer;
                endcase
            end
            default: state_d = StIdle;
        endcase
        // A slave error on any completed access aborts the rest of the sequence.
        if (txn_ack && txn_slverr) begin
            state_d = StError;
            err_d   = ErrSlv;
        end
    end

    always_comb begin
        txn_req   = 1'b0;
        txn_write = 1'b0;
        txn_addr  = '0;
        txn_wdata = '0;
        unique case (state_q)
            StWRstRel: begin
                txn_req   = 1'b1;
                txn_write = 1'b1;
                txn_addr  = CtrlOffset;
                txn_wdata = DataWidth'(CtrlRstRel);
            end
            StWRstAss: begin
                txn_req   = 1'b1;
                txn_write = 1'b1;
                txn_addr  = CtrlOffset;
                txn_wdata = DataWidth'(CtrlRstAss);
            end
            StWClkEn: begin
                txn_req   = 1'b1;
                txn_write = 1'b1;
                txn_addr  = CtrlOffset;
                txn_wdata = DataWidth'(CtrlClkEn);
            end
            StWDeIso: begin
                txn_req   = 1'b1;
                txn_write = 1'b1;
                txn_addr  = CtrlOffset;
                txn_wdata = DataWidth'(CtrlDeIso);
            end
            StRIso: begin
                if (rd_step_q == RdXfer) begin
                    txn_req  = 1'b1;
                    txn_addr = IsolatedOffset;
                end
            end
            default: ;
        endcase
        busy_o     = !(state_q inside {StIdle, StDone, StError});
        done_o     = (state_q == StDone);
        error_o    = (state_q == StError);
        err_code_o = err_q;
    end

    slink_apb_single_txn #(
        .AddrWidth (AddrWidth),
        .DataWidth (DataWidth)
    ) u_txn (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (txn_req),
        .addr_i    (txn_addr),
        .write_i   (txn_write),
        .wdata_i   (txn_wdata),
        .ack_o     (txn_ack),
        .rdata_o   (txn_rdata),
        .slverr_o  (txn_slverr),
        .paddr_o   (paddr_o),
        .psel_o    (psel_o),
        .penable_o (penable_o),
        .pwrite_o  (pwrite_o),
        .pwdata_o  (pwdata_o),
        .pstrb_o   (pstrb_o),
        .pready_i  (pready_i),
        .prdata_i  (prdata_i),
        .pslverr_i (pslverr_i)
    );

endmodule

// File: tb/tb_slink_link_bringup.sv
// Bench for slink_link_bringup: APB slave model, scenario-level timing model, per-cycle compare.
module tb_slink_link_bringup;

    localparam int unsigned W    = 5;
    localparam int unsigned MP   = 4;
    localparam logic [31:0] CTRL = 32'h40;
    localparam logic [31:0] ISO  = 32'h44;

    logic        clk_i = 1'b0;
    logic        rst_i, start_i;
    logic        busy_o, done_o, error_o;
    logic [1:0]  err_code_o;
    logic [31:0] paddr_o, pwdata_o, prdata_i;
    logic        psel_o, penable_o, pwrite_o, pready_i, pslverr_i;
    logic [3:0]  pstrb_o;

    always #5 clk_i = ~clk_i;

    slink_link_bringup #(
        .AddrWidth      (32),
        .DataWidth      (32),
        .CtrlOffset     (CTRL),
        .IsolatedOffset (ISO),
        .WaitCycles     (W),
        .MaxPolls       (MP)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .error_o    (error_o),
        .err_code_o (err_code_o),
        .paddr_o    (paddr_o),
        .psel_o     (psel_o),
        .penable_o  (penable_o),
        .pwrite_o   (pwrite_o),
        .pwdata_o   (pwdata_o),
        .pstrb_o    (pstrb_o),
        .pready_i   (pready_i),
        .prdata_i   (prdata_i),
        .pslverr_i  (pslverr_i)
    );

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scenario configuration
    int          dly [32];
    int          err_idx;
    logic [31:0] iso_v [8];
    int          n_iso;

    // Slave state and transfer log
    int          xidx, rd_cnt, wcnt;
    bit          in_xfer;
    logic [31:0] su_addr, su_wdata;
    logic        su_write;
    logic [3:0]  su_strb;
    logic [31:0] log_addr [$];
    logic [31:0] log_data [$];
    logic        log_wr   [$];

    // Model: outcome, end cycle (relative to start edge) and expected transfers
    bit          m_active = 1'b0;
    int          m_start, m_end, b_end;
    bit          m_done, b_done;
    logic [1:0]  m_code, b_code;
    logic [31:0] e_addr [$];
    logic [31:0] e_data [$];
    logic        e_wr   [$];
    int          first_done_rel;
    int          rel_c;

    function automatic logic [31:0] iso_at(input int p);
        return (p < n_iso) ? iso_v[p] : iso_v[n_iso-1];
    endfunction

    task automatic build_model();
        logic [31:0] wvals [4];
        logic [31:0] v;
        int t, k, p;
        bit fin;
        wvals = '{32'h300, 32'h302, 32'h303, 32'h003};
        e_addr.delete(); e_data.delete(); e_wr.delete();
        t = 1; k = 0; p = 0; fin = 1'b0;
        b_done = 1'b0; b_code = 2'd0;
        for (int i = 0; i < 4 && !fin; i++) begin
            if (i == 3) t += W;
            t += 2 + dly[k];
            e_addr.push_back(CTRL); e_wr.push_back(1'b1); e_data.push_back(wvals[i]);
            if (err_idx == k) begin fin = 1'b1; b_code = 2'd1; end
            k++;
        end
        while (!fin) begin
            t += 2 + dly[k];
            e_addr.push_back(ISO); e_wr.push_back(1'b0); e_data.push_back(32'h0);
            if (err_idx == k) begin
                fin = 1'b1; b_code = 2'd1;
            end else begin
                t += 2;
                v = iso_at(p);
                if (v[1:0] == 2'b00) begin fin = 1'b1; b_done = 1'b1; end
                else if (p + 1 == int'(MP)) begin fin = 1'b1; b_code = 2'd2; end
            end
            k++; p++;
        end
        b_end = t;
    endtask

    task automatic slave_step();
        pready_i = 1'b0; pslverr_i = 1'b0; prdata_i = 32'h0;
        if (rst_i) begin
            in_xfer = 1'b0; wcnt = 0;
        end else if (psel_o && !penable_o) begin
            su_addr = paddr_o; su_write = pwrite_o; su_wdata = pwdata_o; su_strb = pstrb_o;
            in_xfer = 1'b1; wcnt = 0;
        end else if (psel_o && penable_o) begin
            chk("apb_setup_first", 32'(in_xfer), 32'd1);
            chk("apb_addr_stable", paddr_o, su_addr);
            chk("apb_write_stable", 32'(pwrite_o), 32'(su_write));
            chk("apb_wdata_stable", pwdata_o, su_wdata);
            chk("apb_strb_stable", 32'(pstrb_o), 32'(su_strb));
            if (wcnt == dly[xidx]) begin
                pready_i  = 1'b1;
                pslverr_i = (xidx == err_idx);
                if (!pwrite_o) begin
                    prdata_i = iso_at(rd_cnt);
                    rd_cnt++;
                end
                log_addr.push_back(paddr_o);
                log_wr.push_back(pwrite_o);
                log_data.push_back(pwrite_o ? pwdata_o : 32'h0);
                xidx++; in_xfer = 1'b0;
            end else begin
                wcnt++;
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk_i);
            slave_step();
        end
    end

    // Per-cycle compare against the scenario model
    always @(negedge clk_i) begin
        if (chk_en) begin
            if (!m_active) begin
                chk("idle_busy", 32'(busy_o), 32'd0);
                chk("idle_done", 32'(done_o), 32'd0);
                chk("idle_error", 32'(error_o), 32'd0);
                chk("idle_code", 32'(err_code_o), 32'd0);
                chk("idle_psel", 32'(psel_o), 32'd0);
            end else begin
                rel_c = cyc - m_start;
                if (rel_c < m_end) begin
                    chk("run_busy", 32'(busy_o), 32'd1);
                    chk("run_done", 32'(done_o), 32'd0);
                    chk("run_error", 32'(error_o), 32'd0);
                    chk("run_code", 32'(err_code_o), 32'd0);
                end else begin
                    chk("end_busy", 32'(busy_o), 32'd0);
                    chk("end_done", 32'(done_o), 32'(m_done));
                    chk("end_error", 32'(error_o), 32'(!m_done));
                    chk("end_code", 32'(err_code_o), 32'(m_code));
                    chk("end_psel", 32'(psel_o), 32'd0);
                end
                if (done_o && first_done_rel < 0) first_done_rel = rel_c;
            end
            if (psel_o && pwrite_o) begin
                chk("wr_strb", 32'(pstrb_o), 32'hF);
                chk("wr_upper_zero", 32'(pwdata_o[31:10]), 32'd0);
            end
            if (penable_o) chk("penable_needs_psel", 32'(psel_o), 32'd1);
        end
    end

    task automatic setup_default();
        foreach (dly[i]) dly[i] = 0;
        err_idx = -1;
        iso_v[0] = 32'h0;
        n_iso = 1;
    endtask

    task automatic launch();
        int s;
        @(negedge clk_i);
        xidx = 0; rd_cnt = 0; wcnt = 0; in_xfer = 1'b0;
        log_addr.delete(); log_data.delete(); log_wr.delete();
        build_model();
        first_done_rel = -1;
        start_i = 1'b1;
        s = cyc;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        m_start = s; m_end = b_end; m_done = b_done; m_code = b_code;
        m_active = 1'b1;
    endtask

    task automatic finish_run();
        repeat (m_end + 4) @(posedge clk_i);
        #1;
    endtask

    task automatic check_log(input string tag);
        chk({tag, "_ntxn"}, log_addr.size(), e_addr.size());
        for (int i = 0; i < e_addr.size() && i < log_addr.size(); i++) begin
            chk({tag, "_addr"}, log_addr[i], e_addr[i]);
            chk({tag, "_wr"}, 32'(log_wr[i]), 32'(e_wr[i]));
            chk({tag, "_data"}, log_data[i], e_data[i]);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        rst_i = 1'b1; start_i = 1'b0;
        pready_i = 1'b0; prdata_i = 32'h0; pslverr_i = 1'b0;
        setup_default();
        @(posedge clk_i);
        #1;
        chk_en = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_paddr", paddr_o, 32'h0);
        chk("rst_pwdata", pwdata_o, 32'h0);
        chk("rst_pstrb", 32'(pstrb_o), 32'h0);
        chk("rst_pwrite", 32'(pwrite_o), 32'h0);
        chk("rst_penable", 32'(penable_o), 32'h0);
        rst_i = 1'b0;

        // Nominal: zero-wait slave, de-isolated at the first poll
        setup_default();
        launch();
        chk("nom_model_end", m_end, 32'd18);
        finish_run();
        check_log("nom");
        chk("nom_done_cycle", first_done_rel, 32'd18);
        chk("nom_n", log_addr.size(), 32'd5);
        chk("nom_w0", log_data[0], 32'h300);
        chk("nom_w1", log_data[1], 32'h302);
        chk("nom_w2", log_data[2], 32'h303);
        chk("nom_w3", log_data[3], 32'h003);
        chk("nom_raddr", log_addr[4], 32'h44);
        chk("nom_done", 32'(done_o), 32'd1);

        // Slow isolation release, restarted straight from DONE; upper read bits ignored
        setup_default();
        iso_v[0] = 32'h3; iso_v[1] = 32'h1; iso_v[2] = 32'hFFFF_FFF0; n_iso = 3;
        launch();
        finish_run();
        check_log("slow");
        chk("slow_n", log_addr.size(), 32'd7);
        chk("slow_done", 32'(done_o), 32'd1);
        chk("slow_error", 32'(error_o), 32'd0);

        // Poll timeout: ISOLATED stuck at 0x2
        setup_default();
        iso_v[0] = 32'h2;
        launch();
        finish_run();
        check_log("to");
        chk("to_n", log_addr.size(), 32'd8);
        chk("to_error", 32'(error_o), 32'd1);
        chk("to_code", 32'(err_code_o), 32'd2);
        repeat (10) @(posedge clk_i);
        chk("to_quiet", log_addr.size(), 32'd8);

        // Slave error on the 0x302 write, restarted from ERROR
        setup_default();
        err_idx = 1;
        launch();
        finish_run();
        check_log("slv");
        chk("slv_n", log_addr.size(), 32'd2);
        chk("slv_code", 32'(err_code_o), 32'd1);
        chk("slv_error", 32'(error_o), 32'd1);

        // Slave wait states, plus a start pulse while busy that must be ignored
        setup_default();
        dly[0] = 3; dly[1] = 0; dly[2] = 5; dly[3] = 1; dly[4] = 2; dly[5] = 4;
        iso_v[0] = 32'h1; iso_v[1] = 32'h0; n_iso = 2;
        launch();
        repeat (2) @(negedge clk_i);
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        finish_run();
        check_log("ws");
        chk("ws_done", 32'(done_o), 32'd1);

        // Reset during WAIT, then a full replay
        setup_default();
        launch();
        while (cyc - m_start < 9) @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        m_active = 1'b0;
        @(negedge clk_i);
        chk("mid_rst_busy", 32'(busy_o), 32'd0);
        chk("mid_rst_psel", 32'(psel_o), 32'd0);
        chk("mid_rst_paddr", paddr_o, 32'h0);
        rst_i = 1'b0;
        repeat (3) @(posedge clk_i);
        launch();
        finish_run();
        check_log("replay");
        chk("replay_w0", log_data[0], 32'h300);
        chk("replay_done", 32'(done_o), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
